itof_pipe: RTL and testbench

- Pipelined converter from signed 32-bit integer to IEEE-754 binary32. It is the reverse of the float-to-integral path (floor/ftoi) in the FPU.
- Three register stages with valid/ready handshakes on both sides, so it can sit behind the FPU issue logic and stall under writeback backpressure.
- Accepts one conversion per cycle when the output is not stalled.

---
 rtl/fpu_pkg.sv | 15 +
 rtl/lzc32.sv | 16 +
 rtl/itof_pipe.sv | 139 +++++++++++++
 tb/tb_itof_pipe.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: binary32 field widths, exponent bias and the
// packed binary32 layout used by the conversion and arithmetic datapaths.
package fpu_pkg;

  localparam int FP32_BIAS   = 127;
  localparam int FP32_MANT_W = 23;
  localparam int FP32_EXP_W  = 8;

  typedef struct packed {
    logic                   sign;
    logic [FP32_EXP_W-1:0]  exp;
    logic [FP32_MANT_W-1:0] mant;
  } fp32_t;

endpackage

// File: rtl/lzc32.sv
// Combinational 32-bit leading-zero counter. Returns 32 for an all-zero
// input. Shared by itof, ftoi and the adder normalizer.
module lzc32 (
  input  logic [31:0] a_i,
  output logic [5:0]  cnt_o
);

  // Scan upward so the highest set bit determines the final count.
  always_comb begin
    cnt_o = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (a_i[i]) cnt_o = 6'(31 - i);
    end
  end

endmodule

// File: rtl/itof_pipe.sv
// Three-stage signed int32 -> binary32 converter with valid/ready on both
// sides. Stage 1 takes sign/magnitude, stage 2 normalizes, stage 3 rounds
// (RNE, or truncation when RTZ=1) and holds the result for the consumer.
// Define ITOF_INEXACT_EN to add the registered 'inexact' output.
module itof_pipe
  import fpu_pkg::*;
#(
  parameter int RTZ = 0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y
`ifdef ITOF_INEXACT_EN
  ,
  output logic        inexact
`endif
);

  // Exponent of a value whose leading one sits at bit 31.
  localparam logic [7:0] EXP_TOP = 8'(FP32_BIAS + 31);

  logic        v1_q, v2_q, v3_q;
  logic        s1_q, s2_q;
  logic [31:0] mag1_q, mag1_d;
  logic [30:0] norm2_q, norm2_d;
  logic [7:0]  exp2_q, exp2_d;
  logic        zero2_q;
  logic [5:0]  lz;
  fp32_t       y_q, y_d;
  logic        en1, en2, en3;
  logic [22:0] mant;
  logic        guard, sticky, round_up;
  logic [23:0] mant_r;
  logic [7:0]  exp_r;

  // A stage may load when it is empty or its contents move on this edge.
  assign en3      = !v3_q || out_ready;
  assign en2      = !v2_q || en3;
  assign en1      = !v1_q || en2;
  assign in_ready = en1;

  assign out_valid = v3_q;
  assign y         = y_q;

  // 0x80000000 negates to itself, which is exactly the wanted magnitude.
  assign mag1_d = x[31] ? (~x + 32'd1) : x;

  lzc32 u_lzc (
    .a_i   (mag1_q),
    .cnt_o (lz)
  );

  // The leading one is implicit, so only bits below it are carried forward.
  assign norm2_d = mag1_q[30:0] << lz;
  assign exp2_d  = EXP_TOP - {2'b00, lz};

  assign mant     = norm2_q[30:8];
  assign guard    = norm2_q[7];
  assign sticky   = |norm2_q[6:0];
  assign round_up = (RTZ == 0) && guard && (sticky || mant[0]);
  assign mant_r   = {1'b0, mant} + {23'd0, round_up};
  assign exp_r    = exp2_q + {7'd0, mant_r[23]};

  // Pack the rounded result; a zero magnitude always yields +0.
  always_comb begin
    y_d = '0;
    if (!zero2_q) begin
      y_d.sign = s2_q;
      y_d.exp  = exp_r;
      y_d.mant = mant_r[22:0];
    end
  end

  // Stage 1: capture sign and magnitude of an accepted operand.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1_q   <= 1'b0;
      s1_q   <= 1'b0;
      mag1_q <= '0;
    end else if (en1) begin
      v1_q <= in_valid;
      if (in_valid) begin
        s1_q   <= x[31];
        mag1_q <= mag1_d;
      end
    end
  end

  // Stage 2: normalized fraction and biased exponent.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v2_q    <= 1'b0;
      s2_q    <= 1'b0;
      norm2_q <= '0;
      exp2_q  <= '0;
      zero2_q <= 1'b0;
    end else if (en2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        s2_q    <= s1_q;
        norm2_q <= norm2_d;
        exp2_q  <= exp2_d;
        zero2_q <= lz[5];
      end
    end
  end

  // Stage 3: rounded result, held while the consumer stalls.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v3_q <= 1'b0;
      y_q  <= '0;
    end else if (en3) begin
      v3_q <= v2_q;
      if (v2_q) y_q <= y_d;
    end
  end

`ifdef ITOF_INEXACT_EN
  logic inexact_q;

  assign inexact = inexact_q;

  // Discarded fraction bits flag the result as inexact, regardless of mode.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inexact_q <= 1'b0;
    end else if (en3 && v2_q) begin
      inexact_q <= guard || sticky;
    end
  end
`endif

endmodule

// File: tb/tb_itof_pipe.sv
// Self-checking bench for itof_pipe: directed conversions, tie rounding,
// backpressure, mid-stream reset and a randomized handshake run, checked
// against an arithmetic int -> binary32 reference and a result queue.
module tb_itof_pipe;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] x = '0;
  logic        in_ready, out_valid, in_ready_z, out_valid_z;
  logic [31:0] y, y_z;
`ifdef ITOF_INEXACT_EN
  logic        inexact, inexact_z;
`endif

  always #5 clk = ~clk;

  itof_pipe #(.RTZ(0)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
`ifdef ITOF_INEXACT_EN
    ,
    .inexact   (inexact)
`endif
  );

  itof_pipe #(.RTZ(1)) dut_z (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready_z),
    .x         (x),
    .out_valid (out_valid_z),
    .out_ready (out_ready),
    .y         (y_z)
`ifdef ITOF_INEXACT_EN
    ,
    .inexact   (inexact_z)
`endif
  );

  typedef struct {
    logic [31:0] y_rne;
    logic [31:0] y_rtz;
    logic        inex;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  bit   in_fire, out_fire;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %h required %h", tag, obs, expv);
  endtask

  task automatic check1(input string tag, input logic obs, input logic expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %b required %b", tag, obs, expv);
  endtask

  // {inexact, binary32}: exact value m*2^0 expressed as q*2^(e-23), with the
  // dropped remainder compared against half an ulp.
  function automatic logic [32:0] ref_cvt(input logic [31:0] xv, input bit rtz);
    longint m, q, rem, half;
    int     e, sh;
    bit     s;
    s = xv[31];
    m = longint'($signed(xv));
    if (m < 0) m = -m;
    if (m == 0) return 33'd0;
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    rem = 0;
    if (e <= 23) begin
      q = m << (23 - e);
    end else begin
      sh   = e - 23;
      q    = m >> sh;
      rem  = m - (q << sh);
      half = longint'(1) << (sh - 1);
      if (!rtz && (rem > half || (rem == half && q[0]))) q = q + 1;
      if (q == (longint'(1) << 24)) begin
        q = q >> 1;
        e = e + 1;
      end
    end
    return {rem != 0, s, 8'(e + 127), 23'(q)};
  endfunction

  task automatic push(input logic [31:0] xv);
    exp_t        e;
    logic [32:0] r;
    r       = ref_cvt(xv, 1'b0);
    e.y_rne = r[31:0];
    e.inex  = r[32];
    r       = ref_cvt(xv, 1'b1);
    e.y_rtz = r[31:0];
    sb.push_back(e);
  endtask

  // One clock: sample handshakes at the falling edge, score any retiring
  // result, then record an accepted operand just after the rising edge.
  task automatic tick();
    logic [31:0] xs;
    exp_t        e;
    @(negedge clk);
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    xs       = x;
    check1("in_ready_rtz", in_ready_z, in_ready);
    if (out_fire) begin
      check1("sb_nonempty", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("y_rne", y, e.y_rne);
        check("y_rtz", y_z, e.y_rtz);
        check1("valid_rtz", out_valid_z, 1'b1);
`ifdef ITOF_INEXACT_EN
        check1("inexact", inexact, e.inex);
        check1("inexact_rtz", inexact_z, e.inex);
`endif
      end
    end
    @(posedge clk);
    #1;
    if (in_fire) push(xs);
  endtask

  // Single operand with an idle pipe: checks acceptance, latency and value.
  task automatic single(input string tag, input logic [31:0] xv, input logic [31:0] e_rne,
                        input logic [31:0] e_rtz, input logic e_inex);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    x         = xv;
    #1;
    check1({tag, "_in_ready"}, in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    x        = $urandom;
    check1({tag, "_lat1"}, out_valid, 1'b0);
    tick();
    check1({tag, "_lat2"}, out_valid, 1'b0);
    tick();
    check1({tag, "_lat3"}, out_valid, 1'b1);
    check({tag, "_rne"}, y, e_rne);
    check({tag, "_rtz"}, y_z, e_rtz);
`ifdef ITOF_INEXACT_EN
    check1({tag, "_inexact"}, inexact, e_inex);
`else
    if (e_inex === 1'bx) check1({tag, "_inexact_arg"}, e_inex, 1'b0);
`endif
    tick();
  endtask

  function automatic logic [31:0] rand_x();
    logic [31:0] r;
    case ($urandom_range(0, 3))
      0: r = $urandom;
      1: r = $urandom >> $urandom_range(0, 31);
      2: r = -($urandom >> $urandom_range(0, 31));
      default: begin
        case ($urandom_range(0, 4))
          0: r = 32'h0000_0000;
          1: r = 32'h8000_0000;
          2: r = 32'h7FFF_FFFF;
          3: r = 32'h0100_0001 + 32'($urandom_range(0, 7));
          default: r = 32'hFF00_0000 - 32'($urandom_range(0, 7));
        endcase
      end
    endcase
    return r;
  endfunction

  logic [31:0] bp_tab [6];
  int          nx, acc;

  initial begin
    bp_tab = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000,
               32'h4080_0000, 32'h40A0_0000, 32'h40C0_0000};

    // Reset state
    #2;
    check1("rst_out_valid", out_valid, 1'b0);
    check("rst_y", y, 32'h0);
    check1("rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check1("post_rst_out_valid", out_valid, 1'b0);
    check1("post_rst_in_ready", in_ready, 1'b1);

    // Basic, extreme and tie conversions
    single("p3",    32'h0000_0003, 32'h4040_0000, 32'h4040_0000, 1'b0);
    single("m12",   32'hFFFF_FFF4, 32'hC140_0000, 32'hC140_0000, 1'b0);
    single("m1",    32'hFFFF_FFFF, 32'hBF80_0000, 32'hBF80_0000, 1'b0);
    single("zero",  32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0);
    single("intmin",32'h8000_0000, 32'hCF00_0000, 32'hCF00_0000, 1'b0);
    single("intmax",32'h7FFF_FFFF, 32'h4F00_0000, 32'h4EFF_FFFF, 1'b1);
    single("tie_lo",32'd16777217,  32'h4B80_0000, 32'h4B80_0000, 1'b1);
    single("tie_up",32'd16777219,  32'h4B80_0002, 32'h4B80_0001, 1'b1);
    single("exact", 32'd16777218,  32'h4B80_0001, 32'h4B80_0001, 1'b0);
    check("sb_after_directed", 32'(sb.size()), 32'd0);

    // Backpressure: three accepted, then stall with y held
    out_ready = 1'b0;
    nx  = 1;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      x        = 32'(nx);
      tick();
      if (in_fire) begin
        nx++;
        acc++;
      end
      if (c >= 2) begin
        check1("bp_valid", out_valid, 1'b1);
        check("bp_hold", y, 32'h3F80_0000);
      end
    end
    check("bp_accepts", 32'(acc), 32'd3);
    check1("bp_in_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_valid = (nx <= 6);
      x        = 32'(nx);
      #1;
      check1("bp_stream_valid", out_valid, 1'b1);
      check("bp_order", y, bp_tab[k]);
      tick();
      if (in_fire) nx++;
    end
    in_valid = 1'b0;
    check("bp_all_accepted", 32'(nx), 32'd7);
    check1("bp_drained", out_valid, 1'b0);

    // Randomized operands and handshakes
    for (int c = 0; c < 400; c++) begin
      if (!in_valid || in_fire) begin
        in_valid = ($urandom_range(0, 3) != 0);
        x        = rand_x();
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && sb.size() != 0; c++) tick();
    check("rand_drain", 32'(sb.size()), 32'd0);

    // Reset with operands in flight
    out_ready = 1'b0;
    in_valid  = 1'b1;
    x         = 32'd7;
    tick();
    x = 32'd9;
    tick();
    in_valid = 1'b0;
    tick();
    check1("pre_rst_valid", out_valid, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    check1("rst_async_valid", out_valid, 1'b0);
    check("rst_async_y", y, 32'h0);
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rstn      = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      check1("no_stale", out_valid, 1'b0);
    end
    single("after_rst", 32'd5, 32'h40A0_0000, 32'h40A0_0000, 1'b0);
    check("sb_final", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "timeout");
  end

endmodule
